// File: rtl/phase_comp_cal_seq.sv
`default_nettype none
// ============================================================================
// Module   : phase_comp_cal_seq
// Purpose  : Calibration sequencer for the 16-lane coarse phase-compensator
//            control block. Preloads every lane with INIT_CODE, then runs
//            tracking bursts. After each burst it reads every lane back and
//            freezes the lanes whose code has settled.
// Options  : CAL_TIMEOUT_EN - when defined, stop after MAX_PASS bursts and
//            flag timeout if some lanes are still open.
// Revision : 1.0 - initial release
// ============================================================================
module phase_comp_cal_seq #(
    parameter int            DW           = 10,
    parameter logic [DW-1:0] INIT_CODE    = DW'('h200),
    parameter int            TRACK_CYCLES = 256,
    parameter int            LOCK_TOL     = 2,
    parameter int            MAX_PASS     = 8
) (
    input  logic          clk,
    input  logic          resetb,
    input  logic          start,
    input  logic          abort,
    input  logic [DW-1:0] reg_read_data,
    output logic          enable,
    output logic          en_mid,
    output logic [15:0]   freeze,
    output logic [3:0]    reg_num,
    output logic          reg_write_readb,
    output logic [DW-1:0] reg_load_data,
    output logic          busy,
    output logic          done,
    output logic          timeout
);

    localparam int TCW = $clog2(TRACK_CYCLES);

    // Parameter sanity: burst length must be a multiple of 16 and at least 16;
    // the pass limit must fit the saturating 8-bit pass counter.
    if ((TRACK_CYCLES < 16) || ((TRACK_CYCLES % 16) != 0)) begin : g_bad_track_cycles
        $error("TRACK_CYCLES must be a multiple of 16 and >= 16");
    end
    if ((MAX_PASS < 1) || (MAX_PASS > 255)) begin : g_bad_max_pass
        $error("MAX_PASS must be in 1..255");
    end

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PRELOAD = 3'd1,
        S_TRACK   = 3'd2,
        S_CHECK   = 3'd3,
        S_EVAL    = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     idx_q, idx_d;
    logic [TCW-1:0] tcnt_q, tcnt_d;
    logic [7:0]     pass_q, pass_d;
    logic [15:0]    freeze_q, freeze_d;
    logic           done_q, done_d;
    logic           snap_we;

    // Per-lane snapshot of the code seen at the previous check
    logic [DW-1:0]  snap_q [16];
    logic [DW-1:0]  snap_rd;
    logic [DW-1:0]  diff;
    logic           lane_settled;
    logic           pass_limit_hit;

`ifdef CAL_TIMEOUT_EN
    logic           timeout_q, timeout_d;
`endif

    // Unsigned magnitude of the code change; computed without wrap-around so
    // a jump across full scale is seen as a large move, not a small one.
    assign snap_rd        = snap_q[idx_q];
    assign diff           = (reg_read_data >= snap_rd) ? (reg_read_data - snap_rd)
                                                       : (snap_rd - reg_read_data);
    assign lane_settled   = (32'(diff) <= 32'(LOCK_TOL));
    assign pass_limit_hit = ((32'(pass_q) + 32'd1) == 32'(MAX_PASS));

    // Next-state and output decode
    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        tcnt_d          = tcnt_q;
        pass_d          = pass_q;
        freeze_d        = freeze_q;
        done_d          = done_q;
        snap_we         = 1'b0;
        enable          = 1'b0;
        en_mid          = 1'b0;
        reg_num         = 4'd0;
        reg_write_readb = 1'b0;
        reg_load_data   = '0;
`ifdef CAL_TIMEOUT_EN
        timeout_d       = timeout_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d  = S_PRELOAD;
                    idx_d    = 4'd0;
                    pass_d   = 8'd0;
                    freeze_d = 16'h0000;
                    done_d   = 1'b0;
`ifdef CAL_TIMEOUT_EN
                    timeout_d = 1'b0;
`endif
                end
            end

            S_PRELOAD: begin
                reg_write_readb = 1'b1;
                reg_num         = idx_q;
                reg_load_data   = INIT_CODE;
                idx_d           = idx_q + 4'd1;
                if (idx_q == 4'd15) begin
                    state_d = S_TRACK;
                    tcnt_d  = TCW'(TRACK_CYCLES - 1);
                end
            end

            S_TRACK: begin
                enable = 1'b1;
                en_mid = (pass_q != 8'd0);
                if (tcnt_q == '0) begin
                    state_d = S_CHECK;
                    idx_d   = 4'd0;
                end else begin
                    tcnt_d = tcnt_q - TCW'(1);
                end
            end

            S_CHECK: begin
                reg_num = idx_q;
                snap_we = 1'b1;
                // The first check only seeds the snapshots; locking needs a
                // previous reading to compare against.
                if ((pass_q != 8'd0) && lane_settled) begin
                    freeze_d[idx_q] = 1'b1;
                end
                idx_d = idx_q + 4'd1;
                if (idx_q == 4'd15) begin
                    state_d = S_EVAL;
                end
            end

            S_EVAL: begin
                pass_d = (pass_q == 8'hFF) ? pass_q : (pass_q + 8'd1);
                if (freeze_q == 16'hFFFF) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
`ifdef CAL_TIMEOUT_EN
                else if (pass_limit_hit) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                end
`endif
                else begin
                    state_d = S_TRACK;
                    tcnt_d  = TCW'(TRACK_CYCLES - 1);
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort wins over everything else: drop to IDLE, keep lock results
        if (abort && (state_q != S_IDLE)) begin
            state_d  = S_IDLE;
            freeze_d = freeze_q;
            done_d   = done_q;
            snap_we  = 1'b0;
`ifdef CAL_TIMEOUT_EN
            timeout_d = timeout_q;
`endif
        end
    end

    // State and control registers
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q  <= S_IDLE;
            idx_q    <= 4'd0;
            tcnt_q   <= '0;
            pass_q   <= 8'd0;
            freeze_q <= 16'h0000;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            tcnt_q   <= tcnt_d;
            pass_q   <= pass_d;
            freeze_q <= freeze_d;
            done_q   <= done_d;
        end
    end

    // Snapshot storage; contents are don't-care after reset, so no reset term
    always_ff @(posedge clk) begin
        if (snap_we) begin
            snap_q[idx_q] <= reg_read_data;
        end
    end

`ifdef CAL_TIMEOUT_EN
    // Sticky timeout flag
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
        end
    end
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign freeze = freeze_q;
    assign done   = done_q;
    assign busy   = (state_q == S_PRELOAD) || (state_q == S_TRACK) ||
                    (state_q == S_CHECK)   || (state_q == S_EVAL);

endmodule
`default_nettype wire

// File: tb/tb_phase_comp_cal_seq.sv
`default_nettype none
module tb_phase_comp_cal_seq;

    localparam int DW = 10;
    localparam int TC = 256;
    localparam int MP = 4;

    logic          clk    = 1'b0;
    logic          resetb = 1'b0;
    logic          start  = 1'b0;
    logic          abort  = 1'b0;
    logic [DW-1:0] reg_read_data;
    logic          enable, en_mid, reg_write_readb, busy, done, timeout;
    logic [15:0]   freeze;
    logic [3:0]    reg_num;
    logic [DW-1:0] reg_load_data;

    int checks = 0;
    int errors = 0;
    int scen   = 0;
    int bursts = 0;
    logic en_prev = 1'b0;
    logic [DW-1:0] model_q [16];

    typedef struct packed {
        logic [3:0]    num;
        logic [DW-1:0] data;
        logic          wr;
    } acc_t;
    typedef struct {
        logic [15:0] frz;
        logic        dn;
        logic        to;
        int          nb;
    } res_t;
    acc_t acc_q[$];
    res_t res_q[$];

    always #5 clk = ~clk;

    phase_comp_cal_seq #(
        .DW(DW), .INIT_CODE(10'h200), .TRACK_CYCLES(TC), .LOCK_TOL(2), .MAX_PASS(MP)
    ) dut (
        .clk(clk), .resetb(resetb), .start(start), .abort(abort),
        .reg_read_data(reg_read_data), .enable(enable), .en_mid(en_mid),
        .freeze(freeze), .reg_num(reg_num), .reg_write_readb(reg_write_readb),
        .reg_load_data(reg_load_data), .busy(busy), .done(done), .timeout(timeout)
    );

    // Control-block model: register file plus per-scenario code drift that is
    // applied once per burst (at the end of the first tracking cycle).
    assign reg_read_data = model_q[reg_num];
    always @(posedge clk) begin
        en_prev <= enable;
        if (start && !busy) bursts <= 0;
        if (reg_write_readb) model_q[reg_num] <= reg_load_data;
        if (enable && !en_prev) begin
            bursts <= bursts + 1;
            if (scen == 1 && !freeze[3]) model_q[3] <= model_q[3] + 10'd8;
            if (scen == 2 && bursts == 0) model_q[0] <= 10'h3FF;
            if (scen == 2 && bursts == 1) model_q[0] <= 10'h000;
        end
    end

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            if (!busy) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        resetb = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({enable, en_mid, freeze, reg_num, reg_write_readb, reg_load_data, busy, done, timeout} !== 36'h0)
            begin errors++; $display("FAIL reset_outputs: got %h required 0", {enable, en_mid, freeze, reg_num, reg_write_readb, reg_load_data, busy, done, timeout}); end
        resetb = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || reg_write_readb !== 1'b0)
            begin errors++; $display("FAIL reset_idle: busy %b wr %b required 0 0", busy, reg_write_readb); end
    endtask

    task automatic test_preload();
        acc_t e;
        int n, midbad;
        scen = 0;
        pulse_start();
        for (int i = 0; i < 16; i++) acc_q.push_back('{4'(i), 10'h200, 1'b1});
        for (int i = 0; i < 16; i++) begin
            e = acc_q.pop_front();
            checks++;
            if ({reg_num, reg_load_data, reg_write_readb} !== e || enable !== 1'b0 || busy !== 1'b1)
                begin errors++; $display("FAIL preload_%0d: got num %h data %h wr %b en %b required num %h data %h wr %b en 0", i, reg_num, reg_load_data, reg_write_readb, enable, e.num, e.data, e.wr); end
            @(negedge clk);
        end
        n = 0; midbad = 0;
        while (enable === 1'b1 && n < 1000) begin
            if (en_mid !== 1'b0 || reg_write_readb !== 1'b0) midbad++;
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != TC) begin errors++; $display("FAIL track_len: got %0d required %0d", n, TC); end
        checks++;
        if (midbad != 0) begin errors++; $display("FAIL track_en_mid: got %0d bad cycles required 0", midbad); end
        for (int i = 0; i < 16; i++) acc_q.push_back('{4'(i), 10'h000, 1'b0});
        for (int i = 0; i < 16; i++) begin
            e = acc_q.pop_front();
            checks++;
            if (reg_num !== e.num || reg_write_readb !== e.wr || enable !== 1'b0)
                begin errors++; $display("FAIL check_read_%0d: got num %h wr %b en %b required num %h wr 0 en 0", i, reg_num, reg_write_readb, enable, e.num); end
            @(negedge clk);
        end
        begin bit ok; wait_idle(ok); end
    endtask

    task automatic test_all_lock();
        res_t r;
        bit ok;
        scen = 0;
        res_q.push_back('{16'hFFFF, 1'b1, 1'b0, 2});
        pulse_start();
        wait_idle(ok);
        r = res_q.pop_front();
        checks++;
        if (!ok) begin errors++; $display("FAIL all_lock_wait: got still busy required idle"); end
        checks++;
        if (freeze !== r.frz || done !== r.dn || timeout !== r.to || busy !== 1'b0)
            begin errors++; $display("FAIL all_lock_result: got frz %h done %b to %b busy %b required %h %b %b 0", freeze, done, timeout, busy, r.frz, r.dn, r.to); end
        checks++;
        if (bursts != r.nb) begin errors++; $display("FAIL all_lock_bursts: got %0d required %0d", bursts, r.nb); end
    endtask

    task automatic test_timeout();
        res_t r;
        bit ok;
        scen = 1;
`ifdef CAL_TIMEOUT_EN
        res_q.push_back('{16'hFFF7, 1'b1, 1'b1, MP});
        pulse_start();
        wait_idle(ok);
`else
        res_q.push_back('{16'hFFF7, 1'b0, 1'b0, MP + 1});
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            if (bursts == MP + 1) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        @(negedge clk);
`endif
        r = res_q.pop_front();
        checks++;
        if (!ok) begin errors++; $display("FAIL timeout_wait: got no event required event"); end
        checks++;
        if (freeze !== r.frz || done !== r.dn || timeout !== r.to)
            begin errors++; $display("FAIL timeout_result: got frz %h done %b to %b required %h %b %b", freeze, done, timeout, r.frz, r.dn, r.to); end
        checks++;
        if (bursts != r.nb) begin errors++; $display("FAIL timeout_bursts: got %0d required %0d", bursts, r.nb); end
`ifndef CAL_TIMEOUT_EN
        abort = 1'b1; @(negedge clk); abort = 1'b0;
`endif
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy: got %b required 0", busy); end
    endtask

    task automatic test_abort();
        int n;
        scen = 1;
        pulse_start();
        n = 0;
        while (freeze !== 16'hFFF7 && n < 20000) begin n++; @(negedge clk); end
        while (enable !== 1'b1 && n < 20000) begin n++; @(negedge clk); end
        checks++;
        if (n >= 20000) begin errors++; $display("FAIL abort_wait: got timeout required burst 3"); end
        repeat (99) @(negedge clk);
        checks++;
        if (enable !== 1'b1 || en_mid !== 1'b1)
            begin errors++; $display("FAIL abort_pre: got en %b en_mid %b required 1 1", enable, en_mid); end
        abort = 1'b1; @(negedge clk); abort = 1'b0;
        checks++;
        if (enable !== 1'b0 || busy !== 1'b0 || freeze !== 16'hFFF7 || done !== 1'b0 || reg_write_readb !== 1'b0)
            begin errors++; $display("FAIL abort_post: got en %b busy %b frz %h done %b wr %b required 0 0 fff7 0 0", enable, busy, freeze, done, reg_write_readb); end
        repeat (3) @(negedge clk);
        pulse_start();
        checks++;
        if (freeze !== 16'h0000 || reg_write_readb !== 1'b1 || reg_num !== 4'd0)
            begin errors++; $display("FAIL abort_restart: got frz %h wr %b num %h required 0000 1 0", freeze, reg_write_readb, reg_num); end
        abort = 1'b1; @(negedge clk); abort = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_preload: got busy %b required 0", busy); end
    endtask

    task automatic test_wrap_diff();
        res_t r;
        bit ok;
        int n;
        scen = 2;
        res_q.push_back('{16'hFFFF, 1'b1, 1'b0, 3});
        pulse_start();
        n = 0;
        while (enable !== 1'b1 && n < 100) begin n++; @(negedge clk); end
        n = 0;
        while (enable === 1'b1 && n < 1000) begin
            start = (n == 10);
            n++;
            @(negedge clk);
            start = 1'b0;
            if (n == 11) begin
                checks++;
                if (enable !== 1'b1 || reg_write_readb !== 1'b0 || busy !== 1'b1)
                    begin errors++; $display("FAIL busy_start: got en %b wr %b busy %b required 1 0 1", enable, reg_write_readb, busy); end
            end
        end
        checks++;
        if (n != TC) begin errors++; $display("FAIL busy_start_len: got %0d required %0d", n, TC); end
        n = 0;
        while (bursts != 3 && n < 20000) begin n++; @(negedge clk); end
        checks++;
        if (freeze !== 16'hFFFE) begin errors++; $display("FAIL wrap_freeze: got %h required fffe", freeze); end
        wait_idle(ok);
        r = res_q.pop_front();
        checks++;
        if (!ok || freeze !== r.frz || done !== r.dn || timeout !== r.to || bursts != r.nb)
            begin errors++; $display("FAIL wrap_result: got ok %b frz %h done %b to %b bursts %0d required 1 %h %b %b %0d", ok, freeze, done, timeout, bursts, r.frz, r.dn, r.to, r.nb); end
    endtask

    task automatic test_async_reset();
        bit ok;
        scen = 0;
        pulse_start();
        repeat (7) @(negedge clk);
        checks++;
        if (reg_num !== 4'd7 || reg_write_readb !== 1'b1)
            begin errors++; $display("FAIL areset_pre: got num %h wr %b required 7 1", reg_num, reg_write_readb); end
        #2 resetb = 1'b0;
        #1;
        checks++;
        if ({enable, en_mid, freeze, reg_num, reg_write_readb, reg_load_data, busy, done, timeout} !== 36'h0)
            begin errors++; $display("FAIL areset_outputs: got %h required 0", {enable, en_mid, freeze, reg_num, reg_write_readb, reg_load_data, busy, done, timeout}); end
        @(negedge clk); resetb = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || reg_write_readb !== 1'b0 || enable !== 1'b0)
            begin errors++; $display("FAIL areset_idle: got busy %b wr %b en %b required 0 0 0", busy, reg_write_readb, enable); end
        pulse_start();
        checks++;
        if (reg_num !== 4'd0 || reg_write_readb !== 1'b1)
            begin errors++; $display("FAIL areset_restart: got num %h wr %b required 0 1", reg_num, reg_write_readb); end
        wait_idle(ok);
        checks++;
        if (!ok || done !== 1'b1 || freeze !== 16'hFFFF)
            begin errors++; $display("FAIL areset_final: got ok %b done %b frz %h required 1 1 ffff", ok, done, freeze); end
    endtask

    initial begin
        test_reset();
        test_preload();
        test_all_lock();
        test_timeout();
        test_abort();
        test_wrap_diff();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
